// File: rtl/wishbone_bus_arbiter.sv
// wishbone_bus_arbiter: round-robin N-master to 1-slave Wishbone classic arbiter
// latency: 1 cycle from master CYC to s_cyc; slave-side mux and ACK/ERR return are combinational
// backpressure: grant locked while the granted master holds CYC; other requesters wait their round-robin turn
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   m_cyc/m_stb/m_we                per-master control, one bit per master
//   m_adr/m_dat_w/m_sel             packed per-master buses, master i at [i*W +: W]
//   m_dat_r, m_ack, m_err           return path (data broadcast, ACK/ERR to granted master only)
//   s_*                             single slave-side Wishbone port
//   o_grant                         one-hot current grant, 0 while idle
// Optional feature macro: WB_ARB_TIMEOUT_EN adds a watchdog that errors a beat
// stalled for TIMEOUT_CYCLES and releases the bus.
module wishbone_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_MASTERS-1:0]                m_cyc,
    input  logic [NUM_MASTERS-1:0]                m_stb,
    input  logic [NUM_MASTERS-1:0]                m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_w,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel,
    output logic [DATA_WIDTH-1:0]                 m_dat_r,
    output logic [NUM_MASTERS-1:0]                m_ack,
    output logic [NUM_MASTERS-1:0]                m_err,
    output logic                                  s_cyc,
    output logic                                  s_stb,
    output logic                                  s_we,
    output logic [ADDR_WIDTH-1:0]                 s_adr,
    output logic [DATA_WIDTH-1:0]                 s_dat_w,
    output logic [DATA_WIDTH/8-1:0]               s_sel,
    input  logic [DATA_WIDTH-1:0]                 s_dat_r,
    input  logic                                  s_ack,
    input  logic                                  s_err,
    output logic [NUM_MASTERS-1:0]                o_grant
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = $clog2(NUM_MASTERS);

    typedef enum logic {S_IDLE = 1'b0, S_GRANTED = 1'b1} state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    // r_last doubles as the index of the granted master while in S_GRANTED
    logic [IW-1:0]          r_last, w_last_nxt;
    logic [IW-1:0]          w_pick;
    logic                   w_found;
    logic                   w_active;
    logic                   w_timeout;

    logic                   w_cyc, w_stb, w_we;
    logic [ADDR_WIDTH-1:0]  w_adr;
    logic [DATA_WIDTH-1:0]  w_dat_w;
    logic [SW-1:0]          w_sel;

    // Reset gates the slave side immediately so nothing is forwarded in a reset cycle
    assign w_active = (r_state == S_GRANTED) && !reset;

    // Round-robin search starting one past the last grant, wrapping at NUM_MASTERS
    always_comb begin : pick_next
        logic [IW:0] v_sum;
        w_pick  = r_last;
        w_found = 1'b0;
        v_sum   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            v_sum = {1'b0, r_last} + (IW+1)'(k);
            if (v_sum >= (IW+1)'(NUM_MASTERS)) begin
                v_sum = v_sum - (IW+1)'(NUM_MASTERS);
            end
            if (!w_found && m_cyc[v_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = v_sum[IW-1:0];
            end
        end
    end

    // Select the granted master's request fields
    always_comb begin
        w_cyc   = 1'b0;
        w_stb   = 1'b0;
        w_we    = 1'b0;
        w_adr   = '0;
        w_dat_w = '0;
        w_sel   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_last == IW'(i)) begin
                w_cyc   = m_cyc[i];
                w_stb   = m_stb[i];
                w_we    = m_we[i];
                w_adr   = m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_dat_w = m_dat_w[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel   = m_sel[i*SW +: SW];
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);

    logic [CW-1:0] r_tmo_cnt;

    // Counter holds the number of completed stalled STB cycles; the watchdog fires
    // in the cycle that would bring it to TIMEOUT_CYCLES.
    assign w_timeout = w_active && w_stb && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || r_state == S_IDLE || s_ack || s_err) begin
            r_tmo_cnt <= '0;
        end else if (w_stb) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign s_cyc   = w_active && w_cyc && !w_timeout;
    assign s_stb   = w_active && w_stb && !w_timeout;
    assign s_we    = w_active && w_we;
    assign s_adr   = w_active ? w_adr   : '0;
    assign s_dat_w = w_active ? w_dat_w : '0;
    assign s_sel   = w_active ? w_sel   : '0;
    assign m_dat_r = s_dat_r;
    assign o_grant = r_grant;

    always_comb begin
        m_ack = '0;
        m_err = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_ack[i] = w_active && r_grant[i] && s_ack && m_stb[i] && !w_timeout;
            m_err[i] = w_active && r_grant[i] && ((s_err && m_stb[i]) || w_timeout);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANTED;
                    w_grant_nxt = NUM_MASTERS'(1) << w_pick;
                    w_last_nxt  = w_pick;
                end
            end
            S_GRANTED: begin
                // Lock holds until the owner drops CYC (or the watchdog fires)
                if (!w_cyc || w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end
endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// tb_wishbone_bus_arbiter: directed tests for the 2-master and 4-master arbiter
// latency: n/a (bench)
// backpressure: n/a (bench)
module tb_wishbone_bus_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // 2-master instance
    logic        rst2;
    logic [1:0]  m2_cyc, m2_stb, m2_we, m2_ack, m2_err, g2;
    logic [63:0] m2_adr, m2_dat_w;
    logic [7:0]  m2_sel;
    logic [31:0] m2_dat_r, s2_adr, s2_dat_w, s2_dat_r;
    logic [3:0]  s2_sel;
    logic        s2_cyc, s2_stb, s2_we, s2_ack, s2_err;

    // 4-master instance
    logic         rst4;
    logic [3:0]   m4_cyc, m4_stb, m4_we, m4_ack, m4_err, g4;
    logic [127:0] m4_adr, m4_dat_w;
    logic [15:0]  m4_sel;
    logic [31:0]  m4_dat_r, s4_adr, s4_dat_w, s4_dat_r;
    logic [3:0]   s4_sel;
    logic         s4_cyc, s4_stb, s4_we, s4_ack, s4_err;

    wishbone_bus_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) u_dut2 (
        .clk(clk), .reset(rst2),
        .m_cyc(m2_cyc), .m_stb(m2_stb), .m_we(m2_we), .m_adr(m2_adr), .m_dat_w(m2_dat_w), .m_sel(m2_sel),
        .m_dat_r(m2_dat_r), .m_ack(m2_ack), .m_err(m2_err),
        .s_cyc(s2_cyc), .s_stb(s2_stb), .s_we(s2_we), .s_adr(s2_adr), .s_dat_w(s2_dat_w), .s_sel(s2_sel),
        .s_dat_r(s2_dat_r), .s_ack(s2_ack), .s_err(s2_err), .o_grant(g2)
    );

    wishbone_bus_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) u_dut4 (
        .clk(clk), .reset(rst4),
        .m_cyc(m4_cyc), .m_stb(m4_stb), .m_we(m4_we), .m_adr(m4_adr), .m_dat_w(m4_dat_w), .m_sel(m4_sel),
        .m_dat_r(m4_dat_r), .m_ack(m4_ack), .m_err(m4_err),
        .s_cyc(s4_cyc), .s_stb(s4_stb), .s_we(s4_we), .s_adr(s4_adr), .s_dat_w(s4_dat_w), .s_sel(s4_sel),
        .s_dat_r(s4_dat_r), .s_ack(s4_ack), .s_err(s4_err), .o_grant(g4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset2();
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
    endtask

    task automatic test_reset();
        rst2 = 1'b1;
        tick();
        tick();
        n_cmp++; if (g2 !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", g2); end
        n_cmp++; if (s2_cyc !== 1'b0) begin n_bad++; $display("FAIL reset_s_cyc: got %b want 0", s2_cyc); end
        n_cmp++; if (s2_adr !== 32'h0) begin n_bad++; $display("FAIL reset_s_adr: got %h want 0", s2_adr); end
        // requests and a stray ACK while reset is held must not produce a grant or ACK
        m2_cyc = 2'b11; m2_stb = 2'b11; s2_ack = 1'b1;
        #1;
        n_cmp++; if (m2_ack !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b want 00", m2_ack); end
        tick();
        n_cmp++; if (g2 !== 2'b00) begin n_bad++; $display("FAIL reset_hold_grant: got %b want 00", g2); end
        m2_cyc = 2'b00; m2_stb = 2'b00; s2_ack = 1'b0;
        rst2 = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        reset2();
        m2_cyc = 2'b01; m2_stb = 2'b01;
        s2_ack = 1'b1;  // arrives in IDLE: ignored
        #1;
        n_cmp++; if (s2_cyc !== 1'b0) begin n_bad++; $display("FAIL read_latency: s_cyc got %b want 0", s2_cyc); end
        n_cmp++; if (m2_ack !== 2'b00) begin n_bad++; $display("FAIL idle_ack: got %b want 00", m2_ack); end
        s2_ack = 1'b0;
        tick();
        n_cmp++; if (s2_cyc !== 1'b1) begin n_bad++; $display("FAIL read_s_cyc: got %b want 1", s2_cyc); end
        n_cmp++; if (s2_adr !== 32'h100) begin n_bad++; $display("FAIL read_s_adr: got %h want 100", s2_adr); end
        n_cmp++; if (s2_we !== 1'b0) begin n_bad++; $display("FAIL read_s_we: got %b want 0", s2_we); end
        n_cmp++; if (g2 !== 2'b01) begin n_bad++; $display("FAIL read_grant: got %b want 01", g2); end
        s2_ack = 1'b1; s2_dat_r = 32'hDEADBEEF;
        #1;
        n_cmp++; if (m2_ack !== 2'b01) begin n_bad++; $display("FAIL read_ack: got %b want 01", m2_ack); end
        n_cmp++; if (m2_dat_r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_data: got %h want deadbeef", m2_dat_r); end
        tick();
        s2_ack = 1'b0; m2_cyc = 2'b00; m2_stb = 2'b00;
        tick();
        n_cmp++; if (g2 !== 2'b00) begin n_bad++; $display("FAIL read_release: got %b want 00", g2); end
    endtask

    task automatic test_round_robin();
        reset2();
        m2_cyc = 2'b11; m2_stb = 2'b11;
        tick();
        n_cmp++; if (g2 !== 2'b01) begin n_bad++; $display("FAIL rr_first: got %b want 01", g2); end
        m2_cyc = 2'b10; m2_stb = 2'b10;
        tick();
        n_cmp++; if (g2 !== 2'b00) begin n_bad++; $display("FAIL rr_idle_gap: got %b want 00", g2); end
        n_cmp++; if (s2_cyc !== 1'b0) begin n_bad++; $display("FAIL rr_idle_s_cyc: got %b want 0", s2_cyc); end
        tick();
        n_cmp++; if (g2 !== 2'b10) begin n_bad++; $display("FAIL rr_second: got %b want 10", g2); end
        n_cmp++; if (s2_adr !== 32'h200) begin n_bad++; $display("FAIL rr_m1_adr: got %h want 200", s2_adr); end
        n_cmp++; if (s2_dat_w !== 32'h12345678) begin n_bad++; $display("FAIL rr_m1_dat: got %h want 12345678", s2_dat_w); end
        n_cmp++; if (s2_sel !== 4'b0011) begin n_bad++; $display("FAIL rr_m1_sel: got %b want 0011", s2_sel); end
        n_cmp++; if (s2_we !== 1'b1) begin n_bad++; $display("FAIL rr_m1_we: got %b want 1", s2_we); end
        m2_cyc = 2'b00; m2_stb = 2'b00;
        tick();
        m2_cyc = 2'b11; m2_stb = 2'b11;
        tick();
        n_cmp++; if (g2 !== 2'b01) begin n_bad++; $display("FAIL rr_wrap: got %b want 01", g2); end
        m2_cyc = 2'b00; m2_stb = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        reset2();
        m2_cyc = 2'b11; m2_stb = 2'b11;
        tick();
        n_cmp++; if (g2 !== 2'b01) begin n_bad++; $display("FAIL lock_start: got %b want 01", g2); end
        for (int b = 0; b < 4; b++) begin
            s2_ack = 1'b1;
            #1;
            n_cmp++; if (m2_ack !== 2'b01) begin n_bad++; $display("FAIL lock_ack beat %0d: got %b want 01", b, m2_ack); end
            n_cmp++; if (g2 !== 2'b01) begin n_bad++; $display("FAIL lock_grant beat %0d: got %b want 01", b, g2); end
            tick();
        end
        s2_ack = 1'b0; m2_cyc = 2'b10; m2_stb = 2'b10;
        #1;
        n_cmp++; if (g2 !== 2'b01) begin n_bad++; $display("FAIL lock_held: got %b want 01", g2); end
        tick();
        n_cmp++; if (g2 !== 2'b00) begin n_bad++; $display("FAIL lock_gap: got %b want 00", g2); end
        tick();
        n_cmp++; if (g2 !== 2'b10) begin n_bad++; $display("FAIL lock_handover: got %b want 10", g2); end
        m2_cyc = 2'b00; m2_stb = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_four_masters();
        logic [3:0] exp_g [5];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        m4_cyc = 4'hF; m4_stb = 4'hF;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (g4 !== exp_g[k]) begin n_bad++; $display("FAIL rr4_grant %0d: got %b want %b", k, g4, exp_g[k]); end
            s4_ack = 1'b1;
            #1;
            n_cmp++; if (m4_ack !== exp_g[k]) begin n_bad++; $display("FAIL rr4_ack %0d: got %b want %b", k, m4_ack, exp_g[k]); end
            tick();
            s4_ack = 1'b0;
            m4_cyc = ~exp_g[k]; m4_stb = ~exp_g[k];
            tick();
            n_cmp++; if (g4 !== 4'b0000) begin n_bad++; $display("FAIL rr4_gap %0d: got %b want 0000", k, g4); end
            m4_cyc = 4'hF; m4_stb = 4'hF;
            tick();
        end
        m4_cyc = 4'h0; m4_stb = 4'h0;
        tick();
    endtask

    task automatic test_reset_midbeat();
        reset2();
        m2_cyc = 2'b10; m2_stb = 2'b10;
        tick();
        n_cmp++; if (g2 !== 2'b10) begin n_bad++; $display("FAIL rst_mid_grant: got %b want 10", g2); end
        rst2 = 1'b1; s2_ack = 1'b1;
        #1;
        n_cmp++; if (m2_ack !== 2'b00) begin n_bad++; $display("FAIL rst_mid_ack: got %b want 00", m2_ack); end
        tick();
        n_cmp++; if (s2_cyc !== 1'b0) begin n_bad++; $display("FAIL rst_mid_s_cyc: got %b want 0", s2_cyc); end
        n_cmp++; if (g2 !== 2'b00) begin n_bad++; $display("FAIL rst_mid_clear: got %b want 00", g2); end
        rst2 = 1'b0; s2_ack = 1'b0;
        m2_cyc = 2'b11; m2_stb = 2'b11;
        tick();
        n_cmp++; if (g2 !== 2'b01) begin n_bad++; $display("FAIL rst_mid_pointer: got %b want 01", g2); end
        m2_cyc = 2'b00; m2_stb = 2'b00;
        tick();
        tick();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int hit;
        hit = 0;
        reset2();
        m2_cyc = 2'b01; m2_stb = 2'b01;
        tick();
        for (int c = 1; c <= 40 && hit == 0; c++) begin
            if (m2_err[0] === 1'b1) hit = c;
            else tick();
        end
        n_cmp++; if (hit != 16) begin n_bad++; $display("FAIL timeout_cycle: got %0d want 16", hit); end
        tick();
        n_cmp++; if (s2_cyc !== 1'b0) begin n_bad++; $display("FAIL timeout_s_cyc: got %b want 0", s2_cyc); end
        n_cmp++; if (g2 !== 2'b00) begin n_bad++; $display("FAIL timeout_grant: got %b want 00", g2); end
        m2_cyc = 2'b00; m2_stb = 2'b00;
        tick();
        tick();
    endtask
`else
    task automatic test_timeout();
        int drops;
        drops = 0;
        reset2();
        m2_cyc = 2'b01; m2_stb = 2'b01;
        tick();
        for (int c = 0; c < 120; c++) begin
            if (g2 !== 2'b01 || s2_cyc !== 1'b1 || m2_err !== 2'b00) drops++;
            tick();
        end
        n_cmp++; if (drops != 0) begin n_bad++; $display("FAIL stuck_hold: lost grant on %0d cycles, want 0", drops); end
        n_cmp++; if (g2 !== 2'b01) begin n_bad++; $display("FAIL stuck_grant: got %b want 01", g2); end
        m2_cyc = 2'b00; m2_stb = 2'b00;
        tick();
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst2 = 1'b1; rst4 = 1'b1;
        m2_cyc = '0; m2_stb = '0; m2_we = 2'b10;
        m2_adr   = {32'h0000_0200, 32'h0000_0100};
        m2_dat_w = {32'h1234_5678, 32'h0000_0000};
        m2_sel   = {4'b0011, 4'b1111};
        s2_dat_r = '0; s2_ack = 1'b0; s2_err = 1'b0;
        m4_cyc = '0; m4_stb = '0; m4_we = '0;
        m4_adr = '0; m4_dat_w = '0; m4_sel = '0;
        s4_dat_r = '0; s4_ack = 1'b0; s4_err = 1'b0;

        test_reset();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_four_masters();
        test_reset_midbeat();
        test_timeout();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
